// File: rtl/compression_dictionary.sv
// compression_dictionary: writable key/value dictionary with a registered forward
// lookup (key -> value) and a registered CAM-style reverse lookup (value -> key).
// Reverse misses can optionally allocate into the entry at a round-robin pointer.
module compression_dictionary #(
    parameter int unsigned KEY_WIDTH     = 4,
    parameter int unsigned VAL_WIDTH     = 32,
    parameter bit          ALLOC_ON_MISS = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 wr_en,
    input  logic [KEY_WIDTH-1:0] wr_key,
    input  logic [VAL_WIDTH-1:0] wr_val,
    input  logic                 fwd_req,
    input  logic [KEY_WIDTH-1:0] fwd_key,
    output logic                 fwd_resp,
    output logic                 fwd_hit,
    output logic [VAL_WIDTH-1:0] fwd_val,
    input  logic                 rev_req,
    input  logic [VAL_WIDTH-1:0] rev_val,
    output logic                 rev_resp,
    output logic                 rev_hit,
    output logic                 rev_alloc,
    output logic [KEY_WIDTH-1:0] rev_key,
    output logic [KEY_WIDTH:0]   occupancy,
    output logic                 full
);
    localparam int unsigned DEPTH     = 2**KEY_WIDTH;
    localparam int unsigned OCC_WIDTH = KEY_WIDTH + 1;

    logic [VAL_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0]     valid;
    logic [KEY_WIDTH-1:0] alloc_ptr;

    logic                 rev_match_c;
    logic [KEY_WIDTH-1:0] rev_match_key_c;
    logic                 alloc_c;
    logic                 occ_inc_c;
    logic [OCC_WIDTH-1:0] occ_next_c;

    // Parallel compare against valid entries; scanning downward lets the lowest index win
    always_comb begin
        rev_match_c     = 1'b0;
        rev_match_key_c = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (valid[i] && (mem[i] == rev_val)) begin
                rev_match_c     = 1'b1;
                rev_match_key_c = KEY_WIDTH'(i);
            end
        end
    end

    // Allocation decision and next occupancy; flush and explicit writes take priority
    always_comb begin
        alloc_c    = ALLOC_ON_MISS && rev_req && !rev_match_c && !wr_en && !flush;
        occ_inc_c  = 1'b0;
        if (wr_en && !valid[wr_key]) begin
            occ_inc_c = 1'b1;
        end
        if (alloc_c && !valid[alloc_ptr]) begin
            occ_inc_c = 1'b1;
        end
        occ_next_c = flush ? '0 : (occupancy + OCC_WIDTH'(occ_inc_c));
    end

    // Value storage: no reset needed since invalid entries are never visible
    always_ff @(posedge clk) begin
        if (!reset && !flush) begin
            if (wr_en) begin
                mem[wr_key] <= wr_val;
            end else if (alloc_c) begin
                mem[alloc_ptr] <= rev_val;
            end
        end
    end

    // Valid bits, allocation pointer, occupancy counter and registered responses
    always_ff @(posedge clk) begin
        if (reset) begin
            valid     <= '0;
            alloc_ptr <= '0;
            occupancy <= '0;
            full      <= 1'b0;
            fwd_resp  <= 1'b0;
            fwd_hit   <= 1'b0;
            fwd_val   <= '0;
            rev_resp  <= 1'b0;
            rev_hit   <= 1'b0;
            rev_alloc <= 1'b0;
            rev_key   <= '0;
        end else begin
            if (flush) begin
                valid     <= '0;
                alloc_ptr <= '0;
            end else if (wr_en) begin
                valid[wr_key] <= 1'b1;
            end else if (alloc_c) begin
                valid[alloc_ptr] <= 1'b1;
                alloc_ptr        <= alloc_ptr + KEY_WIDTH'(1);
            end
            occupancy <= occ_next_c;
            full      <= (occ_next_c == OCC_WIDTH'(DEPTH));

            fwd_resp  <= fwd_req;
            fwd_hit   <= fwd_req && valid[fwd_key];
            fwd_val   <= (fwd_req && valid[fwd_key]) ? mem[fwd_key] : '0;

            rev_resp  <= rev_req;
            rev_hit   <= rev_req && rev_match_c;
            rev_alloc <= alloc_c;
            if (rev_req && rev_match_c) begin
                rev_key <= rev_match_key_c;
            end else if (alloc_c) begin
                rev_key <= alloc_ptr;
            end else begin
                rev_key <= '0;
            end
        end
    end
endmodule

// File: doc/compression_dictionary.md
# compression_dictionary

Writable, parametrised dictionary for the code-compression datapath: DEPTH = 2**KEY_WIDTH entries of VAL_WIDTH bits, each with a valid bit. It provides a registered forward lookup (key -> value) for the decompressor and a registered reverse, CAM-style lookup (value -> key) for the compressor. It can be loaded explicitly, flushed, and can optionally learn missed values by round-robin allocation. It succeeds the fixed, combinational, pre-initialised lookup table.

## Interface
- KEY_WIDTH, 4, index width; DEPTH = 2**KEY_WIDTH
- VAL_WIDTH, 32, stored value width
- ALLOC_ON_MISS, 1, 1 = a reverse-lookup miss writes the value into the entry at alloc_ptr
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- flush  in  1  invalidate all entries, alloc_ptr <= 0
- wr_en  in  1  explicit write strobe
- wr_key  in  KEY_WIDTH  explicit write index
- wr_val  in  VAL_WIDTH  explicit write data
- fwd_req  in  1  forward lookup request
- fwd_key  in  KEY_WIDTH  forward lookup index
- fwd_resp  out  1  forward response valid
- fwd_hit  out  1  indexed entry was valid
- fwd_val  out  VAL_WIDTH  stored value; 0 on miss
- rev_req  in  1  reverse lookup request
- rev_val  in  VAL_WIDTH  value to search for
- rev_resp  out  1  reverse response valid
- rev_hit  out  1  a valid entry matched
- rev_alloc  out  1  miss caused an allocation
- rev_key  out  KEY_WIDTH  matching index on hit, allocated index on rev_alloc, else 0
- occupancy  out  KEY_WIDTH+1  number of valid entries, 0..DEPTH
- full  out  1  occupancy == DEPTH

## Operation
- Reset:
  - All valid bits, alloc_ptr, occupancy and every output are cleared to 0.
  - Stored values are don't-care after reset and never visible, because fwd_val reads 0 on an invalid entry.
- Lookups use the array state from before the current edge.
  - A write, allocation or flush in the same cycle is not visible to that cycle's response.
- Forward lookup: fwd_hit = valid[fwd_key]; fwd_val = mem[fwd_key] if valid, else 0.
- Reverse lookup:
  - Compares rev_val against all valid entries in parallel.
  - With several matches, the lowest index wins.
  - Invalid entries never match, even if the stale value equals rev_val.
- Allocation:
  - Occurs on a reverse miss when ALLOC_ON_MISS = 1, wr_en = 0 and flush = 0.
  - Writes mem[alloc_ptr] = rev_val, sets valid, and responds rev_alloc = 1, rev_key = alloc_ptr.
  - alloc_ptr then increments modulo DEPTH, wrapping DEPTH-1 -> 0.
  - When full, allocation evicts the entry at alloc_ptr and occupancy stays at DEPTH.
- Explicit write:
  - Sets mem[wr_key] = wr_val and valid[wr_key] = 1.
  - Does not move alloc_ptr.
  - occupancy increments only if the entry was invalid.
- Simultaneous events, in priority order:
  - reset
  - flush: the write and any allocation in that cycle are dropped; lookups still respond.
  - wr_en: a pending allocation is suppressed; the miss responds rev_hit = 0, rev_alloc = 0, rev_key = 0.
  - allocation
- occupancy is kept as a registered counter that follows every valid-bit change; it is not recomputed combinationally.

## Timing
- Latency is 1 cycle.
  - fwd_resp is fwd_req delayed by one cycle; rev_resp is rev_req delayed by one cycle.
  - Data outputs are valid only while the matching *_resp is high.
  - Outside a response cycle, data outputs return to 0.
- Full throughput: a new forward and a new reverse request are accepted every cycle, independently, with no stall or backpressure.
- A write or allocation at edge N is visible to a lookup issued in cycle N+1, which responds at edge N+2.
- full and occupancy update on the same edge as the valid-bit change.
- Reset asserted mid-operation:
  - Any in-flight response is dropped.
  - *_resp is 0 in the cycle after reset.

## Test plan
- Reset, then forward-look up keys 0..15 -> every response has fwd_hit = 0, fwd_val = 0; occupancy = 0, full = 0.
- Write key 1 = 0x2 and key 5 = 0x2, then reverse-look up 0x2 -> rev_hit = 1, rev_key = 1 (lowest index); forward key 5 -> fwd_val = 0x2; occupancy = 2.
- From reset with ALLOC_ON_MISS = 1, issue 17 distinct reverse misses 0x100..0x110 -> rev_alloc = 1 with rev_key = 0..15, then 0; full asserts after the 16th; the 17th evicts key 0, so a reverse lookup of 0x100 misses and allocates at key 1.
- Same cycle: a reverse miss on 0xAA and wr_en to key 3 = 0xBB -> rev_hit = 0, rev_alloc = 0; key 3 holds 0xBB; alloc_ptr unchanged.
- Write key 2 = 0x55 and look up key 2 in the same cycle -> fwd_hit = 0; the lookup issued the next cycle returns 0x55.
- With 4 entries valid, assert flush alongside wr_en -> occupancy = 0, the write is dropped, and the next allocation uses key 0. Repeat with reset asserted while a reverse request is in flight -> no rev_resp in the following cycle.
